keymap_matrix_engine: RTL and testbench

KEYMAP_MATRIX_ENGINE -- requirements
Module: keymap_matrix_engine

---
 rtl/keymap_matrix_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_keymap_matrix_engine.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keymap_matrix_engine.sv
// Turns key events into an active-low key matrix. Held keys live in a slot table,
// the matrix is rebuilt from that table after each change, and the CPU can read/write the map.
module keymap_matrix_engine #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 5,
  parameter int unsigned SCAN_W    = 8,
  parameter int unsigned MODS      = 3,
  parameter int unsigned KEYS      = 2,
  parameter int unsigned SLOTS     = 8,
  parameter int unsigned FORCE_ROW = 7,
  parameter int unsigned FORCE_COL = 1,
  parameter string       MAPFILE   = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scan_valid,
  input  logic [SCAN_W-1:0]      scan,
  input  logic                   released,
  input  logic [MODS-1:0]        mods,
  input  logic                   force_key,
  input  logic                   flush,
  input  logic [ROWS-1:0]        sp_row,
  output logic [COLS-1:0]        sp_col,
  input  logic                   cpu_rd,
  input  logic                   cpu_wr,
  input  logic                   cpu_rewind,
  input  logic [7:0]             cpu_din,
  output logic [7:0]             cpu_dout,
  output logic                   cpu_busy,
  output logic [$clog2(SLOTS):0] held_count,
  output logic                   overflow
);
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned RP2   = 1 << RW;
  localparam int unsigned KB    = $clog2(KEYS);
  localparam int unsigned EW    = MODS + SCAN_W;
  localparam int unsigned AW    = EW + KB;
  localparam int unsigned DEPTH = 1 << EW;
  localparam int unsigned SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CW    = $clog2(SLOTS) + 1;
  localparam logic [RW-1:0] FR  = RW'(FORCE_ROW);
  localparam logic [$clog2(COLS)-1:0] FC = $clog2(COLS)'(FORCE_COL);

  typedef enum logic [2:0] {
    IDLE, READMAP, STORE, REBUILD, COMMIT, CPUREAD, CPUWRITE, CPUINC
  } state_t;

  state_t                  state;
  logic                    pend_valid, pend_rel, ev_rel;
  logic [SCAN_W-1:0]       pend_scan, ev_scan;
  logic [MODS-1:0]         pend_mods, ev_mods;
  logic                    flush_q, rewind_q, rd_q, wr_q;
  logic                    flush_req, rewind_req, rd_req, wr_req;
  logic [SLOTS-1:0]        slot_valid;
  logic [SCAN_W-1:0]       slot_scan [SLOTS];
  logic [7:0]              slot_ent  [SLOTS][KEYS];
  logic [7:0]              ent_q     [KEYS];
  logic [7:0]              rd_word   [KEYS];
  logic [SW-1:0]           tgt, rb_idx, match_idx, free_idx;
  logic                    match_hit, free_hit;
  logic [RP2-1:0][COLS-1:0]  acc, acc_next;
  logic [ROWS-1:0][COLS-1:0] matrix, eff;
  logic [AW-1:0]           cpu_addr;
  logic [EW-1:0]           map_addr;

  assign flush_req  = flush | flush_q;
  assign rewind_req = cpu_rewind | rewind_q;
  assign rd_req     = cpu_rd | rd_q;
  assign wr_req     = cpu_wr | wr_q;
  assign cpu_busy   = (state != IDLE);
  assign map_addr   = (state == READMAP) ? {ev_mods, ev_scan} : cpu_addr[AW-1:KB];

  // One map bank per matrix key; bank select is the low counter bits.
  for (genvar b = 0; b < int'(KEYS); b++) begin : g_bank
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (!rst && state == CPUWRITE && cpu_addr[KB-1:0] == KB'(b))
        mem[cpu_addr[AW-1:KB]] <= cpu_din;
    end
    assign rd_word[b] = mem[map_addr];
  end

  // Lowest free slot and slot holding the pending scan code.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    held_count = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (slot_valid[i] && slot_scan[i] == pend_scan) begin
        match_hit = 1'b1;
        match_idx = SW'(i);
      end
      if (!slot_valid[i]) begin
        free_hit = 1'b1;
        free_idx = SW'(i);
      end
      held_count = held_count + CW'(slot_valid[i]);
    end
  end

  always_comb begin
    acc_next = acc;
    if (slot_valid[rb_idx]) begin
      for (int k = 0; k < int'(KEYS); k++)
        acc_next[slot_ent[rb_idx][k][COLS +: RW]] = acc_next[slot_ent[rb_idx][k][COLS +: RW]]
                                                   & ~slot_ent[rb_idx][k][COLS-1:0];
    end
  end

  // Host side sees the committed matrix plus the forced key, AND-ed over selected rows.
  always_comb begin
    eff = matrix;
    if (force_key) eff[FR][FC] = 1'b0;
    sp_col = '1;
    for (int r = 0; r < int'(ROWS); r++)
      if (!sp_row[r]) sp_col = sp_col & eff[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_rel   <= 1'b0;
      pend_scan  <= '0;
      pend_mods  <= '0;
      ev_rel     <= 1'b0;
      ev_scan    <= '0;
      ev_mods    <= '0;
      flush_q    <= 1'b0;
      rewind_q   <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      overflow   <= 1'b0;
      cpu_addr   <= '0;
      cpu_dout   <= '0;
      tgt        <= '0;
      rb_idx     <= '0;
      acc        <= '1;
      matrix     <= '1;
      slot_valid <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        slot_scan[i] <= '0;
        for (int k = 0; k < int'(KEYS); k++) slot_ent[i][k] <= '0;
      end
      for (int k = 0; k < int'(KEYS); k++) ent_q[k] <= '0;
    end else begin
      if (scan_valid) begin
        if (pend_valid) overflow <= 1'b1;
        else begin
          pend_valid <= 1'b1;
          pend_scan  <= scan;
          pend_rel   <= released;
          pend_mods  <= mods;
        end
      end
      if (flush)      flush_q  <= 1'b1;
      if (cpu_rewind) rewind_q <= 1'b1;
      if (cpu_rd)     rd_q     <= 1'b1;
      if (cpu_wr)     wr_q     <= 1'b1;

      case (state)
        IDLE: begin
          if (pend_valid) begin
            // Event moves to a working copy so the pending register can refill.
            pend_valid <= 1'b0;
            ev_scan    <= pend_scan;
            ev_mods    <= pend_mods;
            ev_rel     <= pend_rel;
            if (pend_rel) begin
              if (match_hit) begin
                tgt   <= match_idx;
                state <= STORE;
              end
            end else if (!match_hit) begin
              if (free_hit) begin
                tgt   <= free_idx;
                state <= READMAP;
              end else begin
                overflow <= 1'b1;
              end
            end
          end else if (flush_req) begin
            flush_q    <= 1'b0;
            slot_valid <= '0;
            acc        <= '1;
            rb_idx     <= '0;
            state      <= REBUILD;
          end else if (rewind_req) begin
            rewind_q <= 1'b0;
            cpu_addr <= '0;
          end else if (rd_req) begin
            rd_q  <= 1'b0;
            state <= CPUREAD;
          end else if (wr_req) begin
            wr_q  <= 1'b0;
            state <= CPUWRITE;
          end
        end
        READMAP: begin
          for (int k = 0; k < int'(KEYS); k++) ent_q[k] <= rd_word[k];
          state <= STORE;
        end
        STORE: begin
          if (ev_rel) begin
            slot_valid[tgt] <= 1'b0;
          end else begin
            slot_valid[tgt] <= 1'b1;
            slot_scan[tgt]  <= ev_scan;
            for (int k = 0; k < int'(KEYS); k++) slot_ent[tgt][k] <= ent_q[k];
          end
          acc    <= '1;
          rb_idx <= '0;
          state  <= REBUILD;
        end
        REBUILD: begin
          acc    <= acc_next;
          rb_idx <= rb_idx + SW'(1);
          if (rb_idx == SW'(SLOTS - 1)) state <= COMMIT;
        end
        COMMIT: begin
          matrix <= acc[ROWS-1:0];
          state  <= IDLE;
        end
        CPUREAD: begin
          cpu_dout <= rd_word[cpu_addr[KB-1:0]];
          state    <= CPUINC;
        end
        CPUWRITE: state <= CPUINC;
        CPUINC: begin
          cpu_addr <= cpu_addr + AW'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keymap_matrix_engine.sv
// Bench for keymap_matrix_engine: directed steps plus random key traffic against a
// held-key set model (matrix = per-row union of stored column masks).
module tb_keymap_matrix_engine;
  logic       clk = 1'b0;
  logic       rst, scan_valid, released, force_key, flush;
  logic       cpu_rd, cpu_wr, cpu_rewind, cpu_busy, overflow;
  logic [7:0] scan, sp_row, cpu_din, cpu_dout;
  logic [2:0] mods;
  logic [4:0] sp_col;
  logic [3:0] held_count;

  always #20 clk = ~clk;

  keymap_matrix_engine dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan(scan), .released(released),
    .mods(mods), .force_key(force_key), .flush(flush), .sp_row(sp_row), .sp_col(sp_col),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rewind(cpu_rewind), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_busy(cpu_busy), .held_count(held_count), .overflow(overflow)
  );

  typedef struct packed {
    logic [7:0] sc;
    logic [7:0] e0;
    logic [7:0] e1;
  } held_t;

  held_t      held[$];
  logic [7:0] mmap [2][2048];
  logic       mdl_ovf;
  int         ptr;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void mdl_event(input logic [7:0] sc, input logic rel, input logic [2:0] md);
    int    idx = -1;
    held_t h;
    foreach (held[i]) if (held[i].sc == sc) idx = i;
    if (rel) begin
      if (idx >= 0) held.delete(idx);
    end else if (idx < 0) begin
      if (held.size() >= 8) mdl_ovf = 1'b1;
      else begin
        h.sc = sc;
        h.e0 = mmap[0][{md, sc}];
        h.e1 = mmap[1][{md, sc}];
        held.push_back(h);
      end
    end
  endfunction

  function automatic logic [4:0] exp_row(input int r, input logic fk);
    logic [4:0] v = 5'b11111;
    foreach (held[i]) begin
      if (int'(held[i].e0[7:5]) == r) v = v & ~held[i].e0[4:0];
      if (int'(held[i].e1[7:5]) == r) v = v & ~held[i].e1[4:0];
    end
    if (fk && r == 7) v[1] = 1'b0;
    return v;
  endfunction

  task automatic check_matrix(input string tag);
    logic [7:0] sel;
    logic [4:0] e;
    for (int r = 0; r < 8; r++) begin
      sp_row = ~(8'd1 << r);
      #1;
      check($sformatf("%s_row%0d", tag, r), 32'(sp_col), 32'(exp_row(r, force_key)));
    end
    sel = 8'($urandom);
    sp_row = sel;
    #1;
    e = 5'b11111;
    for (int r = 0; r < 8; r++) if (!sel[r]) e = e & exp_row(r, force_key);
    check($sformatf("%s_sel%02h", tag, sel), 32'(sp_col), 32'(e));
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int budget = 200;
    while (quiet < 3 && budget > 0) begin
      tick();
      quiet = cpu_busy ? 0 : quiet + 1;
      budget--;
    end
    check({tag, "_idle_timeout"}, 32'(quiet >= 3), 32'd1);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_held"}, 32'(held_count), 32'(held.size()));
    check({tag, "_ovf"}, 32'(overflow), 32'(mdl_ovf));
    check_matrix(tag);
  endtask

  task automatic send(input logic [7:0] sc, input logic rel, input logic [2:0] md);
    scan = sc; released = rel; mods = md; scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    held.delete();
    mdl_ovf = 1'b0;
    ptr = 0;
  endtask

  task automatic rewind_op();
    cpu_rewind = 1'b1;
    tick();
    cpu_rewind = 1'b0;
    ptr = 0;
  endtask

  task automatic write_op(input logic [7:0] v);
    cpu_din = v; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    tick();
    tick();
    mmap[ptr % 2][ptr / 2] = v;
    ptr = (ptr + 1) % 4096;
  endtask

  task automatic read_op(input string tag);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    wait_idle(tag);
    check(tag, 32'(cpu_dout), 32'(mmap[ptr % 2][ptr / 2]));
    ptr = (ptr + 1) % 4096;
  endtask

  initial begin
    logic [7:0] pool [12];
    logic [7:0] v;
    logic [7:0] exp_rd;
    rst = 1'b1; scan_valid = 1'b0; released = 1'b0; force_key = 1'b0; flush = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_rewind = 1'b0; scan = '0; mods = '0;
    sp_row = 8'hFF; cpu_din = '0;
    reset_dut();

    // Reset state
    check("rst_busy", 32'(cpu_busy), 32'd0);
    check("rst_dout", 32'(cpu_dout), 32'd0);
    check_state("rst");

    // Fill the whole map; the counter wraps back to 0 afterwards
    rewind_op();
    for (int a = 0; a < 4096; a++) begin
      v = 8'($urandom);
      if (a == 12'h038) v = 8'h21;
      if (a == 12'h039) v = 8'h00;
      write_op(v);
    end
    read_op("wrap_rd");

    // Rewind / write / read sequence
    rewind_op();
    write_op(8'hA5);
    write_op(8'h3C);
    rewind_op();
    cpu_rd = 1'b1; tick(); cpu_rd = 1'b0; wait_idle("rd0");
    check("rd0", 32'(cpu_dout), 32'hA5);
    cpu_rd = 1'b1; tick(); cpu_rd = 1'b0; wait_idle("rd1");
    check("rd1", 32'(cpu_dout), 32'h3C);
    ptr = 2;
    read_op("rd_cnt2");

    // Press latency: matrix changes exactly 12 cycles after the strobe edge
    sp_row = 8'hFD;
    send(8'h1C, 1'b0, 3'b000);
    mdl_event(8'h1C, 1'b0, 3'b000);
    repeat (11) tick();
    check("press_lat11", 32'(sp_col), 32'b11111);
    tick();
    check("press_lat12", 32'(sp_col), 32'b11110);
    check("press_held", 32'(held_count), 32'd1);
    send(8'h1C, 1'b1, 3'b000);
    mdl_event(8'h1C, 1'b1, 3'b000);
    repeat (10) tick();
    check("rel_lat10", 32'(sp_col), 32'b11110);
    tick();
    check("rel_lat11", 32'(sp_col), 32'b11111);
    wait_idle("rel");
    check_state("rel");

    // Release matches on scan only, whatever the modifiers
    send(8'h12, 1'b0, 3'b001);
    mdl_event(8'h12, 1'b0, 3'b001);
    wait_idle("mod_press");
    check_state("mod_press");
    send(8'h12, 1'b1, 3'b000);
    mdl_event(8'h12, 1'b1, 3'b000);
    wait_idle("mod_rel");
    check_state("mod_rel");

    // Stored entries survive a map rewrite and later rebuilds
    send(8'h00, 1'b0, 3'b000);
    mdl_event(8'h00, 1'b0, 3'b000);
    wait_idle("persist_press");
    rewind_op();
    write_op(8'h00);
    send(8'h55, 1'b0, 3'b010);
    mdl_event(8'h55, 1'b0, 3'b010);
    wait_idle("persist_other");
    check_state("persist");
    send(8'h00, 1'b1, 3'b111);
    mdl_event(8'h00, 1'b1, 3'b111);
    wait_idle("persist_rel");
    check_state("persist_rel");

    // Event wins over a simultaneous CPU read; the read is latched and served later
    exp_rd = mmap[ptr % 2][ptr / 2];
    send(8'h66, 1'b0, 3'b000);
    mdl_event(8'h66, 1'b0, 3'b000);
    cpu_rd = 1'b1; tick(); cpu_rd = 1'b0;
    check("prio_busy", 32'(cpu_busy), 32'd1);
    wait_idle("latched_rd");
    check("latched_rd", 32'(cpu_dout), 32'(exp_rd));
    ptr = (ptr + 1) % 4096;
    check_state("latched");

    // Random key traffic
    foreach (pool[i]) pool[i] = 8'($urandom);
    for (int n = 0; n < 40; n++) begin
      logic [7:0] sc;
      logic       rel;
      logic [2:0] md;
      sc  = pool[$urandom_range(0, 11)];
      rel = ($urandom_range(0, 9) < 4);
      md  = 3'($urandom);
      send(sc, rel, md);
      mdl_event(sc, rel, md);
      wait_idle($sformatf("rnd%0d", n));
      check_state($sformatf("rnd%0d", n));
    end

    // Flush drops all held keys
    flush = 1'b1; tick(); flush = 1'b0;
    held.delete();
    wait_idle("flush");
    check_state("flush");

    // Back-to-back strobes: second hits a full pending register
    reset_dut();
    send(8'h21, 1'b0, 3'b000);
    send(8'h22, 1'b0, 3'b000);
    mdl_event(8'h21, 1'b0, 3'b000);
    mdl_ovf = 1'b1;
    wait_idle("pend_drop");
    check_state("pend_drop");

    // Table full: ninth distinct press is dropped
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      logic [2:0] md;
      md = 3'($urandom);
      if (i == 8) begin
        check("full8_held", 32'(held_count), 32'd8);
        check("full8_ovf", 32'(overflow), 32'd0);
      end
      send(8'(8'h40 + i), 1'b0, md);
      mdl_event(8'(8'h40 + i), 1'b0, md);
      wait_idle($sformatf("full%0d", i));
    end
    check("full9_ovf", 32'(overflow), 32'd1);
    check_state("full9");
    force_key = 1'b1;
    check_matrix("full_force");
    force_key = 1'b0;

    // Forced key is combinational and needs no events
    reset_dut();
    force_key = 1'b1;
    sp_row = 8'h7F;
    #1;
    check("force_r7", 32'(sp_col), 32'b11101);
    check("force_busy", 32'(cpu_busy), 32'd0);
    sp_row = 8'hFF;
    #1;
    check("force_nosel", 32'(sp_col), 32'b11111);
    force_key = 1'b0;
    sp_row = 8'h7F;
    #1;
    check("force_off", 32'(sp_col), 32'b11111);

    // Reset in the middle of a rebuild
    send(8'h1C, 1'b0, 3'b000);
    repeat (4) tick();
    check("midrb_busy", 32'(cpu_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    held.delete();
    mdl_ovf = 1'b0;
    ptr = 0;
    check("midrb_idle", 32'(cpu_busy), 32'd0);
    check("midrb_held", 32'(held_count), 32'd0);
    sp_row = 8'h00;
    #1;
    check("midrb_col", 32'(sp_col), 32'b11111);
    repeat (20) tick();
    check_state("midrb_after");
    read_op("midrb_cnt0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
